// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use and multi-cycle MUL
// interlocks, branch flush, registered forwarding selects and a stall counter.
module pipe_hazard_ctrl #(
  parameter int DW      = 32,
  parameter int RAW     = 5,
  parameter int MUL_LAT = 3,
  parameter int FWD_EN  = 1
) (
  input  logic           clk1,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_rs_used,
  input  logic           id_rt_used,
  input  logic           id_wr_en,
  input  logic [RAW-1:0] id_dest,
  input  logic           id_is_load,
  input  logic           id_is_mul,
  input  logic           branch_taken,
  output logic           stall_if,
  output logic           bubble_ex,
  output logic           ex_hold,
  output logic           flush,
  output logic [1:0]     fwd_a_sel,
  output logic [1:0]     fwd_b_sel,
  output logic [15:0]    stall_cnt
);

  localparam int BW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam bit FWD = (FWD_EN != 0);
  localparam logic [BW-1:0] BUSY_INIT = BW'(MUL_LAT - 1);

  if (MUL_LAT < 1 || MUL_LAT > 8 || DW < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: MUL_LAT must be 1..8 and DW positive");
  end

  typedef struct packed {
    logic           vld;
    logic           wr;
    logic [RAW-1:0] dest;
    logic           ld;
  } slot_t;

  // Scoreboard: p0 = EX, p1 = MEM, p2 = WB
  slot_t           slot_p0_q, slot_p1_q, slot_p2_q, slot_p0_d;
  logic [BW-1:0]   busy_q, busy_d;
  logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      a_hit, b_hit;
  logic            rs_use, rt_use, data_hz, adv;

  function automatic logic slot_hit(input slot_t s, input logic [RAW-1:0] src, input logic used);
    return used && s.vld && s.wr && (s.dest != '0) && (s.dest == src);
  endfunction

  // Youngest producer wins: EX over MEM over WB.
  function automatic logic [1:0] fwd_code(input logic [2:0] hit);
    if (hit[0])      return 2'b01;
    else if (hit[1]) return 2'b10;
    else if (hit[2]) return 2'b11;
    return 2'b00;
  endfunction

  assign rs_use = id_valid & id_rs_used;
  assign rt_use = id_valid & id_rt_used;
  assign a_hit  = {slot_hit(slot_p2_q, id_rs, rs_use), slot_hit(slot_p1_q, id_rs, rs_use),
                   slot_hit(slot_p0_q, id_rs, rs_use)};
  assign b_hit  = {slot_hit(slot_p2_q, id_rt, rt_use), slot_hit(slot_p1_q, id_rt, rt_use),
                   slot_hit(slot_p0_q, id_rt, rt_use)};
  assign data_hz = FWD ? (slot_p0_q.ld & (a_hit[0] | b_hit[0])) : ((|a_hit) | (|b_hit));

  // Hazard outputs; a taken branch overrides every interlock.
  always_comb begin
    flush     = branch_taken;
    ex_hold   = 1'b0;
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    if (!branch_taken) begin
      ex_hold   = (busy_q != '0);
      stall_if  = ex_hold | data_hz;
      bubble_ex = ~ex_hold & data_hz;
    end
  end

  assign adv = ~ex_hold;

  always_comb begin
    slot_p0_d = slot_p0_q;
    busy_d    = busy_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    if (branch_taken) begin
      slot_p0_d = '0;
      busy_d    = '0;
      fwd_a_d   = 2'b00;
      fwd_b_d   = 2'b00;
    end else if (ex_hold) begin
      busy_d = busy_q - BW'(1);
    end else if (bubble_ex) begin
      slot_p0_d = '0;
      busy_d    = '0;
      fwd_a_d   = 2'b00;
      fwd_b_d   = 2'b00;
    end else begin
      slot_p0_d.vld  = id_valid;
      slot_p0_d.wr   = id_wr_en;
      slot_p0_d.dest = id_dest;
      slot_p0_d.ld   = id_is_load;
      busy_d  = (id_valid && id_is_mul) ? BUSY_INIT : '0;
      fwd_a_d = FWD ? fwd_code(a_hit) : 2'b00;
      fwd_b_d = FWD ? fwd_code(b_hit) : 2'b00;
    end
    cnt_d = (stall_if && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      slot_p0_q <= '0;
      slot_p1_q <= '0;
      slot_p2_q <= '0;
      busy_q    <= '0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
      cnt_q     <= 16'd0;
    end else begin
      slot_p0_q <= slot_p0_d;
      if (adv) begin
        slot_p1_q <= slot_p0_q;
        slot_p2_q <= slot_p1_q;
      end
      busy_q  <= busy_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations driven by directed and random
// instruction streams, checked every cycle against a pipeline-occupancy model.
module tb_pipe_hazard_ctrl;

  localparam int NI = 3;

  typedef struct {
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       rsu;
    bit       rtu;
    bit       we;
    bit [4:0] dst;
    bit       ld;
    bit       mul;
  } ins_t;

  typedef struct {
    bit       v;
    bit       we;
    bit [4:0] dst;
    bit       ld;
  } slot_t;

  logic clk1  = 1'b0;
  logic rst_n = 1'b1;
  ins_t cur [NI];
  logic bt  [NI];

  logic       id_valid [NI];
  logic [4:0] id_rs [NI];
  logic [4:0] id_rt [NI];
  logic       id_rs_used [NI];
  logic       id_rt_used [NI];
  logic       id_wr_en [NI];
  logic [4:0] id_dest [NI];
  logic       id_is_load [NI];
  logic       id_is_mul [NI];
  logic       stall_if [NI];
  logic       bubble_ex [NI];
  logic       ex_hold [NI];
  logic       flush [NI];
  logic [1:0] fwd_a_sel [NI];
  logic [1:0] fwd_b_sel [NI];
  logic [15:0] stall_cnt [NI];

  for (genvar g = 0; g < NI; g++) begin : g_drv
    assign id_valid[g]   = cur[g].v;
    assign id_rs[g]      = cur[g].rs;
    assign id_rt[g]      = cur[g].rt;
    assign id_rs_used[g] = cur[g].rsu;
    assign id_rt_used[g] = cur[g].rtu;
    assign id_wr_en[g]   = cur[g].we;
    assign id_dest[g]    = cur[g].dst;
    assign id_is_load[g] = cur[g].ld;
    assign id_is_mul[g]  = cur[g].mul;
  end

  always #5 clk1 = ~clk1;

  pipe_hazard_ctrl #(.DW(32), .RAW(5), .MUL_LAT(4), .FWD_EN(1)) u_d0 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid[0]), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
    .id_rs_used(id_rs_used[0]), .id_rt_used(id_rt_used[0]), .id_wr_en(id_wr_en[0]),
    .id_dest(id_dest[0]), .id_is_load(id_is_load[0]), .id_is_mul(id_is_mul[0]),
    .branch_taken(bt[0]), .stall_if(stall_if[0]), .bubble_ex(bubble_ex[0]),
    .ex_hold(ex_hold[0]), .flush(flush[0]), .fwd_a_sel(fwd_a_sel[0]),
    .fwd_b_sel(fwd_b_sel[0]), .stall_cnt(stall_cnt[0]));

  pipe_hazard_ctrl #(.DW(32), .RAW(5), .MUL_LAT(8), .FWD_EN(0)) u_d1 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid[1]), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
    .id_rs_used(id_rs_used[1]), .id_rt_used(id_rt_used[1]), .id_wr_en(id_wr_en[1]),
    .id_dest(id_dest[1]), .id_is_load(id_is_load[1]), .id_is_mul(id_is_mul[1]),
    .branch_taken(bt[1]), .stall_if(stall_if[1]), .bubble_ex(bubble_ex[1]),
    .ex_hold(ex_hold[1]), .flush(flush[1]), .fwd_a_sel(fwd_a_sel[1]),
    .fwd_b_sel(fwd_b_sel[1]), .stall_cnt(stall_cnt[1]));

  pipe_hazard_ctrl #(.DW(32), .RAW(5), .MUL_LAT(1), .FWD_EN(1)) u_d2 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid[2]), .id_rs(id_rs[2]), .id_rt(id_rt[2]),
    .id_rs_used(id_rs_used[2]), .id_rt_used(id_rt_used[2]), .id_wr_en(id_wr_en[2]),
    .id_dest(id_dest[2]), .id_is_load(id_is_load[2]), .id_is_mul(id_is_mul[2]),
    .branch_taken(bt[2]), .stall_if(stall_if[2]), .bubble_ex(bubble_ex[2]),
    .ex_hold(ex_hold[2]), .flush(flush[2]), .fwd_a_sel(fwd_a_sel[2]),
    .fwd_b_sel(fwd_b_sel[2]), .stall_cnt(stall_cnt[2]));

  // Reference model: pipe[d][age] with age 0 = EX, 1 = MEM, 2 = WB.
  slot_t      pipe [NI][3];
  int         busy [NI];
  logic [1:0] sa [NI];
  logic [1:0] sb [NI];
  int         scnt [NI];
  bit         entered [NI];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         chk_en = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 8 : 1;
  endfunction

  function automatic bit fwd_of(input int d);
    return d != 1;
  endfunction

  function automatic ins_t nop();
    ins_t i = '{default: 0};
    return i;
  endfunction

  function automatic ins_t mk(input bit [4:0] dst, input bit [4:0] rs, input bit [4:0] rt,
                              input bit rsu, input bit rtu, input bit ld, input bit mul);
    ins_t i;
    i.v = 1; i.rs = rs; i.rt = rt; i.rsu = rsu; i.rtu = rtu;
    i.we = 1; i.dst = dst; i.ld = ld; i.mul = mul;
    return i;
  endfunction

  function automatic ins_t alu(input bit [4:0] dst, input bit [4:0] rs, input bit [4:0] rt);
    return mk(dst, rs, rt, 1, 1, 0, 0);
  endfunction

  function automatic ins_t lw(input bit [4:0] dst, input bit [4:0] rs);
    return mk(dst, rs, 5'd0, 1, 0, 1, 0);
  endfunction

  function automatic ins_t mul(input bit [4:0] dst, input bit [4:0] rs, input bit [4:0] rt);
    return mk(dst, rs, rt, 1, 1, 0, 1);
  endfunction

  // Age of the youngest in-flight writer of r, or -1 when nothing is pending.
  function automatic int age_of(input int d, input bit [4:0] r, input bit used);
    if (!cur[d].v || !used || r == 5'd0) return -1;
    for (int a = 0; a < 3; a++)
      if (pipe[d][a].v && pipe[d][a].we && pipe[d][a].dst == r) return a;
    return -1;
  endfunction

  function automatic logic [1:0] code(input int age);
    return (age < 0) ? 2'b00 : 2'(age + 1);
  endfunction

  task automatic model_comb(input int d, output bit st, output bit bb, output bit hd,
                            output bit fl, output int ha, output int hb);
    bit hz;
    ha = age_of(d, cur[d].rs, cur[d].rsu);
    hb = age_of(d, cur[d].rt, cur[d].rtu);
    fl = bt[d];
    hd = !fl && busy[d] > 0;
    if (fwd_of(d)) hz = (ha == 0 || hb == 0) && pipe[d][0].ld;
    else           hz = (ha >= 0) || (hb >= 0);
    st = !fl && (hd || hz);
    bb = !fl && !hd && hz;
  endtask

  task automatic shift(input int d);
    pipe[d][2] = pipe[d][1];
    pipe[d][1] = pipe[d][0];
    pipe[d][0] = '{default: 0};
  endtask

  task automatic model_edge(input int d);
    bit st, bb, hd, fl;
    int ha, hb;
    model_comb(d, st, bb, hd, fl, ha, hb);
    entered[d] = 0;
    if (st) scnt[d]++;
    if (fl) begin
      shift(d);
      busy[d] = 0; sa[d] = 2'b00; sb[d] = 2'b00;
    end else if (hd) begin
      busy[d]--;
    end else begin
      shift(d);
      if (bb) begin
        sa[d] = 2'b00; sb[d] = 2'b00; busy[d] = 0;
      end else begin
        pipe[d][0].v   = cur[d].v;
        pipe[d][0].we  = cur[d].we;
        pipe[d][0].dst = cur[d].dst;
        pipe[d][0].ld  = cur[d].ld;
        sa[d] = fwd_of(d) ? code(ha) : 2'b00;
        sb[d] = fwd_of(d) ? code(hb) : 2'b00;
        busy[d] = (cur[d].v && cur[d].mul) ? lat_of(d) - 1 : 0;
        entered[d] = 1;
      end
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < NI; d++) begin
      for (int a = 0; a < 3; a++) pipe[d][a] = '{default: 0};
      busy[d] = 0; sa[d] = 2'b00; sb[d] = 2'b00; scnt[d] = 0; entered[d] = 0;
    end
  endtask

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, want %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    if (rst_n) for (int d = 0; d < NI; d++) model_edge(d);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    #1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present an instruction in ID until it enters EX; report stall cycles and DUT holds seen.
  task automatic issue(input int d, input ins_t i, output int waited, output int holds);
    waited = 0;
    holds = 0;
    cur[d] = i;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (ex_hold[d]) holds++;
      tick();
      if (entered[d]) break;
      waited++;
    end
    chk("issue_enters", d, entered[d], 1);
    cur[d] = nop();
    #1;
  endtask

  always @(negedge clk1) begin
    bit st, bb, hd, fl;
    int ha, hb;
    if (chk_en) begin
      for (int d = 0; d < NI; d++) begin
        model_comb(d, st, bb, hd, fl, ha, hb);
        chk("stall_if", d, stall_if[d], st);
        chk("bubble_ex", d, bubble_ex[d], bb);
        chk("ex_hold", d, ex_hold[d], hd);
        chk("flush", d, flush[d], fl);
        chk("fwd_a_sel", d, fwd_a_sel[d], sa[d]);
        chk("fwd_b_sel", d, fwd_b_sel[d], sb[d]);
        chk("stall_cnt", d, stall_cnt[d], (scnt[d] > 65535) ? 65535 : scnt[d]);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, h;
    for (int d = 0; d < NI; d++) begin cur[d] = nop(); bt[d] = 1'b0; end
    clear_model();
    #3;
    rst_n = 1'b0;
    chk_en = 1;
    bt[0] = 1'b1;
    #1;
    chk("rst_stall_cnt", 0, stall_cnt[0], 0);
    chk("rst_fwd_a", 0, fwd_a_sel[0], 0);
    chk("rst_ex_hold", 0, ex_hold[0], 0);
    chk("rst_stall_if", 0, stall_if[0], 0);
    chk("rst_flush_follows", 0, flush[0], 1);
    bt[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // ADD r3 ; ADD r4,r3,r1 -> EX/MEM forward, no stall
    issue(0, alu(5'd3, 5'd1, 5'd2), w, h);
    issue(0, alu(5'd4, 5'd3, 5'd1), w, h);
    chk("add_add_wait", 0, w, 0);
    chk("add_add_fwd_a", 0, fwd_a_sel[0], 2'b01);
    chk("add_add_fwd_b", 0, fwd_b_sel[0], 2'b00);

    // LW r2 ; ADD r5,r2,r2 -> one bubble, then MEM/WB forward
    do_reset();
    issue(0, lw(5'd2, 5'd1), w, h);
    issue(0, alu(5'd5, 5'd2, 5'd2), w, h);
    chk("lu_wait", 0, w, 1);
    chk("lu_cnt", 0, stall_cnt[0], 1);
    chk("lu_fwd_a", 0, fwd_a_sel[0], 2'b10);
    chk("lu_fwd_b", 0, fwd_b_sel[0], 2'b10);

    // MUL r6 (latency 4) ; ADD r7,r6,r0
    do_reset();
    issue(0, mul(5'd6, 5'd1, 5'd2), w, h);
    issue(0, alu(5'd7, 5'd6, 5'd0), w, h);
    chk("mul_wait", 0, w, 3);
    chk("mul_holds", 0, h, 3);
    chk("mul_cnt", 0, stall_cnt[0], 3);
    chk("mul_fwd_a", 0, fwd_a_sel[0], 2'b01);

    // Branch taken while MUL is busy
    do_reset();
    issue(0, mul(5'd6, 5'd1, 5'd2), w, h);
    chk("br_busy_hold", 0, ex_hold[0], 1);
    bt[0] = 1'b1;
    #1;
    chk("br_flush", 0, flush[0], 1);
    chk("br_hold_overridden", 0, ex_hold[0], 0);
    chk("br_stall_overridden", 0, stall_if[0], 0);
    tick();
    bt[0] = 1'b0;
    #1;
    chk("br_after_hold", 0, ex_hold[0], 0);
    chk("br_after_fwd_a", 0, fwd_a_sel[0], 0);
    chk("br_after_fwd_b", 0, fwd_b_sel[0], 0);
    issue(0, alu(5'd7, 5'd6, 5'd0), w, h);
    chk("br_ex_empty_wait", 0, w, 0);
    chk("br_ex_empty_fwd", 0, fwd_a_sel[0], 2'b10);

    // Interlock-only: ADD r3 ; SUB r8,r3,r3
    do_reset();
    issue(1, alu(5'd3, 5'd1, 5'd2), w, h);
    issue(1, alu(5'd8, 5'd3, 5'd3), w, h);
    chk("nf_wait", 1, w, 3);
    chk("nf_cnt", 1, stall_cnt[1], 3);
    chk("nf_fwd_a", 1, fwd_a_sel[1], 0);
    chk("nf_fwd_b", 1, fwd_b_sel[1], 0);

    // r0 is never a dependency
    do_reset();
    issue(0, alu(5'd0, 5'd1, 5'd2), w, h);
    issue(0, alu(5'd9, 5'd0, 5'd0), w, h);
    chk("r0_alu_wait", 0, w, 0);
    chk("r0_alu_fwd", 0, fwd_a_sel[0], 0);
    issue(0, lw(5'd0, 5'd1), w, h);
    issue(0, alu(5'd9, 5'd0, 5'd0), w, h);
    chk("r0_lw_wait", 0, w, 0);
    chk("r0_lw_fwd", 0, fwd_b_sel[0], 0);
    issue(1, alu(5'd0, 5'd1, 5'd2), w, h);
    issue(1, alu(5'd9, 5'd0, 5'd0), w, h);
    chk("r0_nf_wait", 1, w, 0);

    // Reset in the middle of a MUL hold
    do_reset();
    issue(1, mul(5'd6, 5'd1, 5'd2), w, h);
    tick();
    #1;
    chk("midmul_hold", 1, ex_hold[1], 1);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("midmul_rst_hold", 1, ex_hold[1], 0);
    chk("midmul_rst_cnt", 1, stall_cnt[1], 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midmul_post_hold", 1, ex_hold[1], 0);

    // Random streams on all three configurations
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < NI; d++) begin
        int k;
        cur[d].v   = ($urandom_range(0, 7) != 0);
        cur[d].rs  = 5'($urandom_range(0, 3));
        cur[d].rt  = 5'($urandom_range(0, 3));
        cur[d].rsu = 1'($urandom_range(0, 1));
        cur[d].rtu = 1'($urandom_range(0, 1));
        cur[d].we  = ($urandom_range(0, 3) != 0);
        cur[d].dst = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 9);
        cur[d].ld  = (k < 3);
        cur[d].mul = (k == 3);
        bt[d] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end
    for (int d = 0; d < NI; d++) begin cur[d] = nop(); bt[d] = 1'b0; end

    // Saturation: back-to-back dependent MULs keep the interlock-only core stalled
    do_reset();
    cur[1] = mul(5'd1, 5'd1, 5'd1);
    for (int n = 0; n < 90000 && scnt[1] < 70000; n++) tick();
    cur[1] = nop();
    #1;
    chk("sat_reached", 1, scnt[1] >= 70000, 1);
    chk("sat_stall_cnt", 1, stall_cnt[1], 16'hFFFF);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32: datapath width, informational for bypass-latch sizing.
REQ-002 SHALL have parameter RAW, default 5: register-address width; register 0 is hardwired zero.
REQ-003 SHALL have parameter MUL_LAT, default 3, legal 1..8: cycles a MUL occupies EX.
REQ-004 SHALL have parameter FWD_EN, default 1: 1 = forwarding, 0 = interlock-only.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk1  in  1  rising-edge clock.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port id_valid  in  1  ID holds a real instruction.
REQ-009 SHALL have port id_rs, id_rt  in  RAW each  ID source registers.
REQ-010 SHALL have port id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-011 SHALL have port id_wr_en  in  1  ID instruction writes a register.
REQ-012 SHALL have port id_dest  in  RAW  ID destination register.
REQ-013 SHALL have port id_is_load, id_is_mul  in  1 each  ID instruction class.
REQ-014 SHALL have port branch_taken  in  1  branch resolved taken this cycle.
REQ-015 SHALL have port stall_if  out  1  hold PC and IF/ID.
REQ-016 SHALL have port bubble_ex  out  1  load NOP into ID/EX.
REQ-017 SHALL have port ex_hold  out  1  freeze ID/EX; NOP into EX/MEM.
REQ-018 SHALL have port flush  out  1  kill IF/ID and ID/EX.
REQ-019 SHALL have port fwd_a_sel, fwd_b_sel  out  2 each  registered select used in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass latch.
REQ-020 SHALL have port stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-021 SHALL keep a 3-slot scoreboard (EX, MEM, WB) per slot: valid, wr_en, dest, is_load; advance on every edge unless ex_hold.
REQ-022 A slot SHALL match a source only if valid, wr_en, dest!=0, dest==source and that source's used bit is set.
REQ-023 FWD_EN=1: load-use (EX-slot match with is_load) SHALL assert stall_if and bubble_ex combinationally for exactly one cycle.
REQ-024 FWD_EN=1: when ID enters EX, fwd_x_sel SHALL be 01 on EX-slot match, else 10 on MEM-slot match, else 11 on WB-slot match, else 00; youngest wins.
REQ-025 FWD_EN=0: any matching slot SHALL stall (stall_if=bubble_ex=1); fwd_x_sel SHALL stay 00.
REQ-026 A MUL entering EX SHALL load busy counter with MUL_LAT-1; while counter!=0: stall_if=1, ex_hold=1, bubble_ex=0, counter decrements; MUL_LAT=1 never holds.
REQ-027 During ex_hold fwd_x_sel SHALL hold their value.
REQ-028 flush SHALL equal branch_taken combinationally and override stall, bubble and hold: the EX slot loads invalid, busy counter clears, fwd_x_sel reload 00.
REQ-029 Any ID instruction with id_valid=0 SHALL enter the EX slot invalid and raise no hazard.
REQ-030 stall_cnt SHALL increment on each edge with stall_if=1 and flush=0, saturating at 16'hFFFF.
REQ-031 Latency: hazard outputs combinational from current inputs/state; selects valid the cycle after the ID edge.

Reset
REQ-032 rst_n low SHALL immediately clear all slots to invalid, busy counter to 0, fwd_x_sel to 00, stall_cnt to 0; stall_if, bubble_ex, ex_hold are 0 and flush follows branch_taken.
REQ-033 Reset asserted mid-MUL SHALL abort the hold; first post-reset cycle SHALL have ex_hold=0.

Verification
REQ-034 ADD r3 then ADD r4,r3,r1 back-to-back -> no stall, fwd_a_sel=01 in second EX cycle.
REQ-035 LW r2 then ADD r5,r2,r2 -> one stall cycle, stall_cnt=1, then fwd_a_sel=fwd_b_sel=10.
REQ-036 MUL_LAT=4, MUL r6 then ADD r7,r6,r0 -> ex_hold high 3 cycles, stall_cnt=3, ADD gets fwd_a_sel=01.
REQ-037 branch_taken during MUL busy -> ex_hold drops next cycle, EX slot invalid, selects 00.
REQ-038 FWD_EN=0, ADD r3 then SUB r8,r3,r3 -> 3 stall cycles, selects always 00.
REQ-039 Writes to r0 followed by reads of r0 -> never stall, selects 00; 70000 forced stalls -> stall_cnt=16'hFFFF.
